// File: rtl/irs_dac_pkg.sv
// Shared types and sizing helpers for the IRS serial DAC loader.
// Latency/backpressure: n/a (package only).
package irs_dac_pkg;

   localparam int ERR_CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LATCH,
      ST_FLUSH
   } state_t;

   function automatic int word_len(input int addr_bits, input int dac_bits);
      return addr_bits + dac_bits;
   endfunction

   // clear + per-word (bits + latch) + flush, each slot one full SCLK period
   function automatic int busy_cycles(input int num_dacs, input int addr_bits,
                                      input int dac_bits, input int sclk_div);
      int l;
      l = word_len(addr_bits, dac_bits);
      return 2*sclk_div + num_dacs*(l + 1)*2*sclk_div + l*2*sclk_div;
   endfunction

endpackage

// File: rtl/irs_sclk_phase_gen.sv
// Phase timer: flags the last clk of each SCLK half-period (or double-length phase).
// Latency: combinational flags from a registered counter; no backpressure.
module irs_sclk_phase_gen #(
   parameter int SCLK_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic run_i,
   input  logic long_i,
   input  logic sample_en_i,
   output logic phase_end_o,
   output logic sample_o
);

   localparam int CNT_W = $clog2(2*SCLK_DIV) + 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] limit;

   assign limit       = long_i ? CNT_W'(2*SCLK_DIV - 1) : CNT_W'(SCLK_DIV - 1);
   assign phase_end_o = run_i && (cnt == limit);
   assign sample_o    = phase_end_o && sample_en_i;

   // Every state change coincides with phase_end, so restarting here restarts on entry.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         cnt <= '0;
      else if (!run_i || phase_end_o)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/irs_serial_dac_loader.sv
// Serial DAC init engine: clear, shift NUM_DACS {addr,value} words MSB first, latch each, flush, verify SHOUT.
// Latency: fixed busy_cycles() per run; start_i ignored while busy, no other backpressure.
module irs_serial_dac_loader
   import irs_dac_pkg::*;
#(
   parameter int NUM_DACS  = 8,
   parameter int DAC_BITS  = 12,
   parameter int ADDR_BITS = 3,
   parameter int SCLK_DIV  = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         start_i,
   input  logic [NUM_DACS*DAC_BITS-1:0] dac_values_i,
   input  logic                         irs_shout_i,
   output logic                         irs_sclk_o,
   output logic                         irs_sin_o,
   output logic                         irs_pclk_o,
   output logic                         irs_regclr_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic                         err_o,
   output logic [ERR_CNT_W-1:0]         err_count_o
);

   localparam int L      = word_len(ADDR_BITS, DAC_BITS);
   localparam int BIT_W  = (L > 1) ? $clog2(L) : 1;
   localparam int WORD_W = $clog2(NUM_DACS + 1);

   state_t                       state, state_nxt;
   logic [NUM_DACS*DAC_BITS-1:0] snap;
   logic [BIT_W-1:0]             bit_cnt;
   logic [WORD_W-1:0]            word_cnt;
   logic                         flush_hi;
   logic [ERR_CNT_W-1:0]         err_cnt;
   logic                         done_q;
   logic                         run, long_phase, sample_en, phase_end, sample;
   logic                         last_bit, last_word, cur_bit, exp_bit;
   logic [L-1:0]                 cur_word, prev_word;
   int                           cur_idx, prev_idx;

   function automatic logic [L-1:0] make_word(input logic [NUM_DACS*DAC_BITS-1:0] v, input int k);
      logic [ADDR_BITS-1:0] a;
      a = ADDR_BITS'(k);
      return {a, v[k*DAC_BITS +: DAC_BITS]};
   endfunction

   // word_cnt == NUM_DACS during FLUSH, so prev_word is then the last word loaded
   always_comb begin
      cur_idx  = 0;
      prev_idx = 0;
      if (word_cnt < WORD_W'(NUM_DACS)) cur_idx = int'(word_cnt);
      if (word_cnt != '0) prev_idx = int'(word_cnt) - 1;
      cur_word  = make_word(snap, cur_idx);
      prev_word = (word_cnt == '0) ? '0 : make_word(snap, prev_idx);
   end

   assign last_bit   = (bit_cnt == BIT_W'(L - 1));
   assign last_word  = (word_cnt == WORD_W'(NUM_DACS - 1));
   assign cur_bit    = cur_word[BIT_W'(L - 1) - bit_cnt];
   assign exp_bit    = prev_word[BIT_W'(L - 1) - bit_cnt];
   assign run        = (state != ST_IDLE);
   assign long_phase = (state == ST_CLR) || (state == ST_LATCH);
   assign sample_en  = (state == ST_SHIFT_LO) || ((state == ST_FLUSH) && !flush_hi);

   irs_sclk_phase_gen #(.SCLK_DIV(SCLK_DIV)) u_phase (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .run_i       (run),
      .long_i      (long_phase),
      .sample_en_i (sample_en),
      .phase_end_o (phase_end),
      .sample_o    (sample)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      irs_sclk_o   = 1'b0;
      irs_sin_o    = 1'b0;
      irs_pclk_o   = 1'b0;
      irs_regclr_o = 1'b0;
      case (state)
         ST_IDLE:     if (start_i) state_nxt = ST_CLR;
         ST_CLR: begin
            irs_regclr_o = 1'b1;
            if (phase_end) state_nxt = ST_SHIFT_LO;
         end
         ST_SHIFT_LO: begin
            irs_sin_o = cur_bit;
            if (phase_end) state_nxt = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            irs_sclk_o = 1'b1;
            irs_sin_o  = cur_bit;
            if (phase_end) state_nxt = last_bit ? ST_LATCH : ST_SHIFT_LO;
         end
         ST_LATCH: begin
            irs_pclk_o = 1'b1;
            if (phase_end) state_nxt = last_word ? ST_FLUSH : ST_SHIFT_LO;
         end
         ST_FLUSH: begin
            irs_sclk_o = flush_hi;
            if (phase_end && flush_hi && last_bit) state_nxt = ST_IDLE;
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         snap     <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         flush_hi <= 1'b0;
         err_cnt  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state == ST_FLUSH) && (state_nxt == ST_IDLE);
         if ((state == ST_IDLE) && start_i) begin
            snap     <= dac_values_i;
            err_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            flush_hi <= 1'b0;
         end
         if (sample && (irs_shout_i != exp_bit) && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
         if (phase_end) begin
            case (state)
               ST_SHIFT_HI: bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
               ST_LATCH:    word_cnt <= word_cnt + 1'b1;
               ST_FLUSH: begin
                  flush_hi <= !flush_hi;
                  if (flush_hi) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy_o      = run;
   assign done_o      = done_q;
   assign err_count_o = err_cnt;
   assign err_o       = (err_cnt != '0);

endmodule

// File: tb/tb_irs_serial_dac_loader.sv
// Directed bench: default loader against a 15-bit shift-register loopback, plus a tiny 1-DAC instance.
// Covers timing, latched words, readback errors, saturation, snapshot, chaining and mid-run reset.
module tb_irs_serial_dac_loader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start_a, shout_a, sclk_a, sin_a, pclk_a, regclr_a, busy_a, done_a, err_a;
   logic [95:0] vals_a;
   logic [7:0]  errc_a;
   logic        start_b, shout_b, sclk_b, sin_b, pclk_b, regclr_b, busy_b, done_b, err_b;
   logic [3:0]  vals_b;
   logic [7:0]  errc_b;

   irs_serial_dac_loader dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start_a), .dac_values_i(vals_a),
      .irs_shout_i(shout_a), .irs_sclk_o(sclk_a), .irs_sin_o(sin_a), .irs_pclk_o(pclk_a),
      .irs_regclr_o(regclr_a), .busy_o(busy_a), .done_o(done_a), .err_o(err_a),
      .err_count_o(errc_a)
   );

   irs_serial_dac_loader #(.NUM_DACS(1), .DAC_BITS(4), .ADDR_BITS(1), .SCLK_DIV(1)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start_b), .dac_values_i(vals_b),
      .irs_shout_i(shout_b), .irs_sclk_o(sclk_b), .irs_sin_o(sin_b), .irs_pclk_o(pclk_b),
      .irs_regclr_o(regclr_b), .busy_o(busy_b), .done_o(done_b), .err_o(err_b),
      .err_count_o(errc_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Chip model for dut_a: cleared by regclr, shifts on sclk rise, SHOUT is the MSB
   logic [14:0] sr_a;
   logic        sclk_q_a, pclk_q_a;
   int          pclk_cnt, rise_cnt;
   logic        inj_en, stuck, mon_en;
   logic [95:0] exp_vals;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_a <= '0; sclk_q_a <= 1'b0; pclk_q_a <= 1'b0; pclk_cnt <= 0; rise_cnt <= 0;
      end else begin
         sclk_q_a <= sclk_a;
         pclk_q_a <= pclk_a;
         if (regclr_a) begin
            sr_a <= '0; pclk_cnt <= 0; rise_cnt <= 0;
         end else if (sclk_a && !sclk_q_a) begin
            sr_a     <= {sr_a[13:0], sin_a};
            rise_cnt <= rise_cnt + 1;
         end
         if (pclk_a && !pclk_q_a) begin
            if (mon_en)
               check_eq($sformatf("latch_word%0d", pclk_cnt), 32'(sr_a),
                        32'({pclk_cnt[2:0], exp_vals[pclk_cnt*12 +: 12]}));
            pclk_cnt <= pclk_cnt + 1;
            rise_cnt <= 0;
         end
      end
   end

   // Injection lands on the LO phase after 4 rises of word 3, i.e. its 5th sample
   assign shout_a = stuck | (sr_a[14] ^ (inj_en && pclk_cnt == 3 && rise_cnt == 4 && !sclk_a));

   logic [4:0] sr_b;
   logic       sclk_q_b;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_b <= '0; sclk_q_b <= 1'b0;
      end else begin
         sclk_q_b <= sclk_b;
         if (regclr_b) sr_b <= '0;
         else if (sclk_b && !sclk_q_b) sr_b <= {sr_b[3:0], sin_b};
      end
   end
   assign shout_b = sr_b[4];

   task automatic run_a(input string tag, input bit prestarted, input bit disturb,
                        input bit chain, input bit do_force);
      int n;
      int done_early;
      n = 0;
      done_early = 0;
      if (!prestarted) start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check_eq({tag, "_busy_rise"}, busy_a, 1);
      check_eq({tag, "_err_clear"}, errc_a, 0);
      if (do_force) force dut_a.err_cnt = 8'd254;
      while (busy_a && n < 3000) begin
         if (done_a) done_early++;
         if (do_force && n == 2) release dut_a.err_cnt;
         if (disturb && n == 200) begin
            start_a = 1'b1;
            vals_a  = ~vals_a;
         end else if (disturb && n == 201) begin
            start_a = 1'b0;
         end
         n++;
         @(negedge clk);
      end
      check_eq({tag, "_busy_len"}, n, 1152);
      check_eq({tag, "_done_in_busy"}, done_early, 0);
      check_eq({tag, "_done"}, done_a, 1);
      if (chain) start_a = 1'b1;
      else begin
         @(negedge clk);
         check_eq({tag, "_done_once"}, done_a, 0);
      end
   endtask

   initial begin
      int n, p, rises;
      logic prev;
      logic [4:0] seq;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; vals_a = '0; vals_b = '0;
      inj_en = 1'b0; stuck = 1'b0; mon_en = 1'b1; exp_vals = '0;
      #23;
      check_eq("reset_outs_a", {sclk_a, sin_a, pclk_a, regclr_a, busy_a, done_a, err_a, errc_a}, 0);
      check_eq("reset_outs_b", {sclk_b, sin_b, pclk_b, regclr_b, busy_b, done_b, err_b, errc_b}, 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_after_reset", {busy_a, done_a, regclr_a}, 0);

      for (int k = 0; k < 8; k++) vals_a[k*12 +: 12] = 12'(k * 'h111);
      exp_vals = vals_a;
      run_a("basic", 0, 0, 0, 0);
      check_eq("basic_errc", errc_a, 0);
      check_eq("basic_err", err_a, 0);
      check_eq("basic_pclk_count", pclk_cnt, 8);

      inj_en = 1'b1;
      run_a("inject", 0, 0, 0, 0);
      inj_en = 1'b0;
      check_eq("inject_errc", errc_a, 1);
      check_eq("inject_err", err_a, 1);

      // Expected bits: 135 samples, of which 12 are ones (address bits of words 0..7)
      stuck = 1'b1; vals_a = '0; exp_vals = '0;
      run_a("stuck", 0, 0, 0, 0);
      check_eq("stuck_errc", errc_a, 123);
      check_eq("stuck_err", err_a, 1);
      repeat (5) @(negedge clk);
      check_eq("stuck_errc_hold", errc_a, 123);

      run_a("sat", 0, 0, 0, 1);
      check_eq("sat_errc", errc_a, 255);
      stuck = 1'b0;

      vals_a = 96'h5a3c96e1f00fedcb87654321;
      exp_vals = vals_a;
      run_a("snap", 0, 1, 1, 0);
      check_eq("snap_errc", errc_a, 0);
      exp_vals = vals_a;
      run_a("chain", 1, 0, 0, 0);
      check_eq("chain_errc", errc_a, 0);

      stuck = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      n = 0; p = 0; prev = 1'b0;
      while (n < 3000) begin
         if (pclk_a && !prev) p++;
         if (p == 3) break;
         prev = pclk_a;
         n++;
         @(negedge clk);
      end
      check_eq("rst_reach_latch2", p, 3);
      check_eq("rst_errc_nonzero", errc_a != 0, 1);
      #1 rst_n = 1'b0;
      #1 check_eq("rst_async_outs", {sclk_a, sin_a, pclk_a, regclr_a, busy_a, done_a, err_a, errc_a}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      stuck = 1'b0;
      p = 0;
      for (int i = 0; i < 20; i++) begin
         if (done_a || busy_a) p++;
         @(negedge clk);
      end
      check_eq("rst_no_done", p, 0);
      run_a("rerun", 0, 0, 0, 0);
      check_eq("rerun_errc", errc_a, 0);

      // Small instance: CLR 2 + word 10 + latch 2 + flush 10 = 24 cycles
      for (int t = 0; t < 2; t++) begin
         vals_b = (t == 0) ? 4'b1011 : 4'b0110;
         start_b = 1'b1;
         @(negedge clk);
         start_b = 1'b0;
         n = 0; rises = 0; seq = '0; prev = 1'b0;
         while (busy_b && n < 200) begin
            if (sclk_b && !prev && rises < 5) begin
               seq = {seq[3:0], sin_b};
               rises++;
            end
            prev = sclk_b;
            n++;
            @(negedge clk);
         end
         check_eq($sformatf("small%0d_busy_len", t), n, 24);
         check_eq($sformatf("small%0d_sin_seq", t), seq, {1'b0, vals_b});
         check_eq($sformatf("small%0d_done", t), done_b, 1);
         check_eq($sformatf("small%0d_errc", t), errc_b, 0);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
